// File: rtl/shift_reg_pipo_pkg.sv
// Shared default constants for the parallel-in/parallel-out register family.
package shift_reg_pipo_pkg;

    localparam int unsigned PIPO_WIDTH_DEF = 8;
    localparam int unsigned PIPO_DEPTH_DEF = 1;

endpackage : shift_reg_pipo_pkg

// File: rtl/shift_reg_pipo_stage.sv
// pipo_stage: one WIDTH-bit register with asynchronous active-high reset.
module pipo_stage
    import shift_reg_pipo_pkg::*;
#(
    parameter int unsigned           WIDTH       = PIPO_WIDTH_DEF,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    // Next-state: capture the whole input bus unchanged on every edge.
    always_comb begin
        data_d = d;
    end

    // Storage flop; reset forces RESET_VALUE immediately, without a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= RESET_VALUE;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : pipo_stage

// File: rtl/shift_reg_pipo.sv
// shift_reg_pipo: parallel-in/parallel-out register, optionally chained into
// a DEPTH-cycle delay line. q is driven straight from the last stage flops.
module shift_reg_pipo
    import shift_reg_pipo_pkg::*;
#(
    parameter int unsigned           WIDTH       = PIPO_WIDTH_DEF,
    parameter int unsigned           DEPTH       = PIPO_DEPTH_DEF,
    parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // stage_out[i] is the output of stage i; stage 0 takes d.
    logic [WIDTH-1:0] stage_out [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            pipo_stage #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .d     (d),
                .q     (stage_out[i])
            );
        end else begin : g_chain
            pipo_stage #(
                .WIDTH       (WIDTH),
                .RESET_VALUE (RESET_VALUE)
            ) u_stage (
                .clk   (clk),
                .reset (reset),
                .d     (stage_out[i-1]),
                .q     (stage_out[i])
            );
        end
    end

    assign q = stage_out[DEPTH-1];

endmodule : shift_reg_pipo

// File: tb/tb_shift_reg_pipo.sv
// Testbench for shift_reg_pipo: a DEPTH=1 and a DEPTH=3 instance share the
// clock, reset and input; both are compared against a capture-history model.
`timescale 1ns/1ps
module tb_shift_reg_pipo;

    logic       clk;
    logic       reset;
    logic [7:0] d;
    logic [7:0] q1;
    logic [7:0] q3;

    int checks;
    int errors;

    // History of values captured on rising edges since the last reset.
    logic [7:0] hist [$];

    shift_reg_pipo #(
        .WIDTH (8),
        .DEPTH (1)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q1)
    );

    shift_reg_pipo #(
        .WIDTH (8),
        .DEPTH (3)
    ) dut3 (
        .clk   (clk),
        .reset (reset),
        .d     (d),
        .q     (q3)
    );

    // 200 ns clock period; inputs change 20-80 ns after a rising edge,
    // outputs are sampled 100 ns after it.
    initial clk = 1'b0;
    always #100 clk = ~clk;

    // Reference: reset empties the history, each edge out of reset records d.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
        end else begin
            hist.push_back(d);
            if (hist.size() > 8) void'(hist.pop_front());
        end
    end

    // Output of a delay line of the given depth: the value captured
    // depth-1 edges ago, or the reset value if not enough captures yet.
    function automatic logic [7:0] model_q(int unsigned depth);
        if (hist.size() >= depth) return hist[hist.size() - depth];
        return 8'h00;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        d     = 8'hFF;
        #1;
        checks++;
        if (q1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_immediate_q1: got %h expected %h", q1, 8'h00);
        end
        checks++;
        if (q3 !== 8'h00) begin
            errors++;
            $display("FAIL reset_immediate_q3: got %h expected %h", q3, 8'h00);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #100;
            checks++;
            if (q1 !== 8'h00 || q3 !== 8'h00) begin
                errors++;
                $display("FAIL reset_hold: got q1=%h q3=%h expected 00", q1, q3);
            end
        end
    endtask

    task automatic test_single_load();
        // At negedge: release reset and present A5 ahead of edge N.
        reset = 1'b0;
        d     = 8'hA5;
        @(posedge clk);
        #20 d = 8'h3C;
        #80;
        checks++;
        if (q1 !== 8'hA5) begin
            errors++;
            $display("FAIL single_load_a5: got %h expected %h", q1, 8'hA5);
        end
        checks++;
        if (q3 !== 8'h00) begin
            errors++;
            $display("FAIL single_load_q3_empty: got %h expected %h", q3, 8'h00);
        end
        @(posedge clk);
        #100;
        checks++;
        if (q1 !== 8'h3C) begin
            errors++;
            $display("FAIL single_load_3c: got %h expected %h", q1, 8'h3C);
        end
    endtask

    task automatic test_walking_ones();
        logic [7:0] w;
        @(posedge clk);
        #20 d = 8'h01;
        for (int i = 0; i < 8; i++) begin
            w = 8'h01 << i;
            @(posedge clk);
            #100;
            checks++;
            if (q1 !== w) begin
                errors++;
                $display("FAIL walking_one_%0d: got %h expected %h", i, q1, w);
            end
            checks++;
            if (q3 !== model_q(3)) begin
                errors++;
                $display("FAIL walking_q3_%0d: got %h expected %h", i, q3, model_q(3));
            end
            #20;
            if (i < 7) d = w << 1;
        end
    endtask

    task automatic test_random();
        int unsigned gap;
        for (int n = 0; n < 12; n++) begin
            gap = $urandom_range(0, 14);
            @(posedge clk);
            #(20 + $urandom_range(0, 60));
            d = 8'($urandom);
            // Checked on every cycle of the gap: q must hold steady.
            for (int unsigned c = 0; c <= gap; c++) begin
                @(posedge clk);
                #100;
                checks++;
                if (q1 !== model_q(1)) begin
                    errors++;
                    $display("FAIL random_q1_%0d: got %h expected %h", n, q1, model_q(1));
                end
                checks++;
                if (q3 !== model_q(3)) begin
                    errors++;
                    $display("FAIL random_q3_%0d: got %h expected %h", n, q3, model_q(3));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #20 d = 8'h5A;
        @(posedge clk);
        #100;
        checks++;
        if (q1 !== 8'h5A) begin
            errors++;
            $display("FAIL async_pre_5a: got %h expected %h", q1, 8'h5A);
        end
        #30 reset = 1'b1;
        #5;
        checks++;
        if (q1 !== 8'h00 || q3 !== 8'h00) begin
            errors++;
            $display("FAIL async_assert: got q1=%h q3=%h expected 00", q1, q3);
        end
        @(posedge clk);
        #100;
        checks++;
        if (q1 !== 8'h00 || q3 !== 8'h00) begin
            errors++;
            $display("FAIL async_held: got q1=%h q3=%h expected 00", q1, q3);
        end
        reset = 1'b0;
        d     = 8'hC3;
        @(posedge clk);
        #100;
        checks++;
        if (q1 !== 8'hC3) begin
            errors++;
            $display("FAIL async_reload: got %h expected %h", q1, 8'hC3);
        end
        checks++;
        if (q3 !== model_q(3)) begin
            errors++;
            $display("FAIL async_reload_q3: got %h expected %h", q3, model_q(3));
        end
    endtask

    task automatic test_depth3();
        logic [7:0] vals [4];
        logic [7:0] exp3;
        vals[0] = 8'h11;
        vals[1] = 8'h22;
        vals[2] = 8'h33;
        vals[3] = 8'h44;
        @(negedge clk);
        reset = 1'b1;
        #10 reset = 1'b0;
        d = vals[0];
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #20;
            if (k < 3) d = vals[k + 1];
            #80;
            exp3 = (k >= 2) ? vals[k - 2] : 8'h00;
            checks++;
            if (q3 !== exp3) begin
                errors++;
                $display("FAIL depth3_edge%0d: got %h expected %h", k + 1, q3, exp3);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        d      = 8'hFF;
        test_reset();
        test_single_load();
        test_walking_ones();
        test_random();
        test_async_reset();
        test_depth3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_shift_reg_pipo
